// File: rtl/snd_sequencer.sv
// ============================================================================
// snd_sequencer
// ----------------------------------------------------------------------------
// Note-sequencing controller between the CPU IO logic and the sound generator.
// The CPU pushes (period, duration) entries into a small queue. The sequencer
// plays them back-to-back by loading snd_max_count and pulsing
// snd_latch_max_count, timing each note in milliseconds. When the queue runs
// dry, or on stop, it latches silence (period 0).
//
// Parameters
//   CLK_HZ      clock frequency in Hz. Must be a multiple of 1000, >= 2000.
//   FIFO_DEPTH  note queue entries. Must be a power of 2, >= 2.
//
// Ports
//   clk                  system clock, rising edge
//   rst_async_n          asynchronous active-low reset
//   note_period[25:0]    generator max-count value for the note (0 = rest)
//   note_duration_ms[7:0] note length in ms (0 is played as 1 ms)
//   note_push            enqueue {note_period, note_duration_ms}
//   stop                 flush the queue and silence the output
//   fifo_full            queue holds FIFO_DEPTH entries
//   fifo_count           entries queued, excluding the note now playing
//   overflow             sticky: a push was dropped because the queue was full
//   busy                 a note or mute is in progress, or entries are queued
//   snd_max_count[25:0]  registered generator configuration value
//   snd_latch_max_count  registered one-cycle latch strobe for snd_max_count
// ============================================================================
module snd_sequencer #(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_async_n,
   input  logic [25:0]                  note_period,
   input  logic [7:0]                   note_duration_ms,
   input  logic                         note_push,
   input  logic                         stop,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow,
   output logic                         busy,
   output logic [25:0]                  snd_max_count,
   output logic                         snd_latch_max_count
);

   localparam int TICK = CLK_HZ / 1000;        // clock cycles per millisecond
   localparam int PW   = $clog2(TICK);         // prescaler width, holds 0..TICK-1
   localparam int AW   = $clog2(FIFO_DEPTH);   // queue pointer width
   localparam int CW   = AW + 1;               // queue count width, holds 0..FIFO_DEPTH

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LATCH,
      ST_PLAY,
      ST_MUTE
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t          state_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            overflow_reg;
   logic [25:0]     snd_max_count_reg;
   logic            latch_reg;
   logic [7:0]      ms_reg;
   logic [PW-1:0]   presc_reg;

   // Queue storage: {period, duration}
   logic [33:0]     fifo_mem [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [33:0]     head;
   logic [25:0]     head_period;
   logic [7:0]      head_dur;
   logic [7:0]      head_ms;
   logic            fifo_empty;
   logic            presc_wrap;
   logic            note_end;
   logic            pop;
   logic            push_ok;
   logic            push_drop;

   // The head is read combinationally so that popping an entry and latching
   // its period happen on the same edge; this keeps notes gapless.
   assign head        = fifo_mem[rd_ptr_reg];
   assign head_period = head[33:8];
   assign head_dur    = head[7:0];
   assign head_ms     = (head_dur == 8'd0) ? 8'd1 : head_dur;

   assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
   assign fifo_empty  = (count_reg == '0);

   assign presc_wrap  = (presc_reg == PW'(TICK - 1));
   assign note_end    = (state_reg == ST_PLAY) && presc_wrap && (ms_reg == 8'd1);

   // Fullness comes from the registered count, so a push into a full queue is
   // dropped even when an entry is popped on the same edge.
   assign push_ok     = note_push && !stop && !fifo_full;
   assign push_drop   = note_push && !stop &&  fifo_full;
   assign pop         = !stop && !fifo_empty &&
                        ((state_reg == ST_IDLE) || note_end);

   assign fifo_count          = count_reg;
   assign overflow            = overflow_reg;
   assign busy                = (state_reg != ST_IDLE) || !fifo_empty;
   assign snd_max_count       = snd_max_count_reg;
   assign snd_latch_max_count = latch_reg;

   // ------------------------------------------------------------------------
   // Queue storage write (no reset on the array)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= {note_period, note_duration_ms};
      end
   end

   // ------------------------------------------------------------------------
   // Queue pointers, count and overflow flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (stop) begin
         // Flush: any push or pop on this edge is discarded.
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push_ok && !pop) begin
            count_reg <= count_reg + CW'(1);
         end else if (!push_ok && pop) begin
            count_reg <= count_reg - CW'(1);
         end
         if (push_drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   //
   // Outputs and counters are loaded on the edge that enters LATCH or MUTE,
   // so the strobe is high exactly while the FSM sits in those states. The
   // LATCH cycle counts as the first cycle of the note: the prescaler starts
   // at 0 there, which makes the next strobe land D*TICK cycles after this one.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         state_reg         <= ST_IDLE;
         snd_max_count_reg <= '0;
         latch_reg         <= 1'b0;
         ms_reg            <= '0;
         presc_reg         <= '0;
      end else begin
         latch_reg <= 1'b0;
         if (stop) begin
            if ((state_reg == ST_IDLE) || (state_reg == ST_MUTE)) begin
               // Already silent, or silence already being latched this cycle:
               // no further strobe.
               state_reg <= ST_IDLE;
            end else begin
               state_reg         <= ST_MUTE;
               snd_max_count_reg <= '0;
               latch_reg         <= 1'b1;
            end
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (!fifo_empty) begin
                     state_reg         <= ST_LATCH;
                     snd_max_count_reg <= head_period;
                     latch_reg         <= 1'b1;
                     ms_reg            <= head_ms;
                     presc_reg         <= '0;
                  end
               end

               ST_LATCH: begin
                  // TICK >= 2, so a note can never end in its LATCH cycle.
                  presc_reg <= presc_reg + PW'(1);
                  state_reg <= ST_PLAY;
               end

               ST_PLAY: begin
                  if (presc_wrap) begin
                     presc_reg <= '0;
                     if (ms_reg == 8'd1) begin
                        if (!fifo_empty) begin
                           // Gapless hand-over to the next queued note.
                           state_reg         <= ST_LATCH;
                           snd_max_count_reg <= head_period;
                           latch_reg         <= 1'b1;
                           ms_reg            <= head_ms;
                        end else begin
                           state_reg         <= ST_MUTE;
                           snd_max_count_reg <= '0;
                           latch_reg         <= 1'b1;
                        end
                     end else begin
                        ms_reg <= ms_reg - 8'd1;
                     end
                  end else begin
                     presc_reg <= presc_reg + PW'(1);
                  end
               end

               ST_MUTE: begin
                  state_reg <= ST_IDLE;
               end

               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snd_sequencer.sv
// ============================================================================
// tb_snd_sequencer
// ----------------------------------------------------------------------------
// Directed self-checking bench for snd_sequencer with CLK_HZ=4000 (TICK=4
// cycles per ms) and FIFO_DEPTH=8. Cycle numbering: the edge that samples a
// push is edge 0; "cycle k" is the interval after edge k-1.
// ============================================================================
module tb_snd_sequencer;

   logic        clk = 1'b0;
   logic        rst_async_n;
   logic [25:0] note_period;
   logic [7:0]  note_duration_ms;
   logic        note_push;
   logic        stop;
   logic        fifo_full;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        busy;
   logic [25:0] snd_max_count;
   logic        snd_latch_max_count;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int n;

   always #5 clk = ~clk;

   snd_sequencer #(
      .CLK_HZ     (4000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk                 (clk),
      .rst_async_n         (rst_async_n),
      .note_period         (note_period),
      .note_duration_ms    (note_duration_ms),
      .note_push           (note_push),
      .stop                (stop),
      .fifo_full           (fifo_full),
      .fifo_count          (fifo_count),
      .overflow            (overflow),
      .busy                (busy),
      .snd_max_count       (snd_max_count),
      .snd_latch_max_count (snd_latch_max_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until the latch strobe is seen or the limit expires; n is the
   // number of edges stepped (equals limit on timeout).
   task automatic wait_pulse(input int limit, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!snd_latch_max_count && cnt < limit);
   endtask

   task automatic push_note(input logic [25:0] p, input logic [7:0] d);
      note_period      = p;
      note_duration_ms = d;
      note_push        = 1'b1;
      step();
      note_push        = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_async_n      = 1'b0;
      note_period      = '0;
      note_duration_ms = '0;
      note_push        = 1'b0;
      stop             = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("rst_smc",   snd_max_count, 0);
      check("rst_latch", snd_latch_max_count, 0);
      check("rst_busy",  busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_full",  fifo_full, 0);
      check("rst_ovf",   overflow, 0);
      #10 rst_async_n = 1'b1;
      step();
      step();
      check("rst_idle_latch", snd_latch_max_count, 0);

      // ---------------- 1. reset mid-note ----------------
      push_note(26'd77, 8'd10);
      repeat (5) step();
      check("t1_play_smc",  snd_max_count, 77);
      check("t1_play_busy", busy, 1);
      #2 rst_async_n = 1'b0;
      #1;
      check("t1_rst_smc",   snd_max_count, 0);
      check("t1_rst_latch", snd_latch_max_count, 0);
      check("t1_rst_busy",  busy, 0);
      @(negedge clk) rst_async_n = 1'b1;
      wait_pulse(50, n);
      check("t1_no_pulse_after_release", n, 50);
      check("t1_busy_after_release", busy, 0);
      check("t1_count_after_release", fifo_count, 0);

      // ---------------- 2. single note ----------------
      push_note(26'd12500, 8'd3);
      check("t2_c1_latch", snd_latch_max_count, 0);
      check("t2_c1_count", fifo_count, 1);
      check("t2_c1_busy",  busy, 1);
      wait_pulse(20, n);
      check("t2_first_pulse_cycle", n, 1);
      check("t2_first_pulse_val",   snd_max_count, 12500);
      repeat (4) step();
      check("t2_hold_val",   snd_max_count, 12500);
      check("t2_hold_latch", snd_latch_max_count, 0);
      wait_pulse(20, n);
      check("t2_mute_spacing", n, 8);
      check("t2_mute_val",     snd_max_count, 0);
      check("t2_mute_busy",    busy, 1);
      step();
      check("t2_idle_busy",  busy, 0);
      check("t2_idle_latch", snd_latch_max_count, 0);

      // ---------------- 3. back-to-back with a rest ----------------
      push_note(26'd100, 8'd1);
      check("t3_c1_latch", snd_latch_max_count, 0);
      push_note(26'd200, 8'd2);
      check("t3_c2_latch", snd_latch_max_count, 1);
      check("t3_c2_val",   snd_max_count, 100);
      push_note(26'd0, 8'd1);
      check("t3_c3_latch", snd_latch_max_count, 0);
      check("t3_c3_count", fifo_count, 2);
      wait_pulse(20, n);
      check("t3_note2_spacing", n, 3);
      check("t3_note2_val",     snd_max_count, 200);
      wait_pulse(20, n);
      check("t3_rest_spacing", n, 8);
      check("t3_rest_val",     snd_max_count, 0);
      check("t3_rest_count",   fifo_count, 0);
      wait_pulse(20, n);
      check("t3_mute_spacing", n, 4);
      check("t3_mute_val",     snd_max_count, 0);
      step();
      check("t3_idle_busy", busy, 0);

      // ---------------- 4. overflow ----------------
      for (int i = 1; i <= 10; i++) begin
         push_note(26'(i), 8'd5);
      end
      check("t4_overflow", overflow, 1);
      check("t4_full",     fifo_full, 1);
      check("t4_count",    fifo_count, 8);
      for (int k = 2; k <= 9; k++) begin
         wait_pulse(40, n);
         check($sformatf("t4_note%0d_spacing", k), n, (k == 2) ? 12 : 20);
         check($sformatf("t4_note%0d_val", k), snd_max_count, k);
      end
      wait_pulse(40, n);
      check("t4_mute_spacing", n, 20);
      check("t4_mute_val",     snd_max_count, 0);
      check("t4_ovf_sticky",   overflow, 1);
      step();
      check("t4_idle_busy", busy, 0);

      // ---------------- 5. stop mid-note ----------------
      push_note(26'd300, 8'd10);
      push_note(26'd1, 8'd1);
      push_note(26'd2, 8'd1);
      push_note(26'd3, 8'd1);
      repeat (3) step();
      check("t5_pre_count", fifo_count, 3);
      check("t5_pre_val",   snd_max_count, 300);
      check("t5_pre_ovf",   overflow, 1);
      stop        = 1'b1;
      note_push   = 1'b1;
      note_period = 26'd9;
      step();
      stop      = 1'b0;
      note_push = 1'b0;
      check("t5_mute_latch", snd_latch_max_count, 1);
      check("t5_mute_val",   snd_max_count, 0);
      check("t5_count",      fifo_count, 0);
      check("t5_ovf_clear",  overflow, 0);
      step();
      check("t5_idle_busy",  busy, 0);
      check("t5_idle_latch", snd_latch_max_count, 0);
      wait_pulse(10, n);
      check("t5_no_more_pulses", n, 10);

      // stop while idle: no strobe
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t5_idle_stop_latch", snd_latch_max_count, 0);

      // ---------------- 6. zero duration ----------------
      push_note(26'd50, 8'd0);
      push_note(26'd60, 8'd1);
      check("t6_first_latch", snd_latch_max_count, 1);
      check("t6_first_val",   snd_max_count, 50);
      wait_pulse(10, n);
      check("t6_second_spacing", n, 4);
      check("t6_second_val",     snd_max_count, 60);
      wait_pulse(10, n);
      check("t6_mute_spacing", n, 4);
      check("t6_mute_val",     snd_max_count, 0);
      step();
      check("t6_idle_busy", busy, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
